seq_tx: RTL and testbench

SEQ_TX -- requirements
Module: seq_tx

---
 rtl/seq_tx_pkg.sv | 23 ++
 rtl/seq_tx_shreg.sv | 68 ++++++
 rtl/seq_tx.sv | 130 +++++++++++++
 tb/tb_seq_tx.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/seq_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seq_tx_pkg
// Description : Shared definitions for the seq_tx serial pattern transmitter.
//               Holds the control FSM state encoding and the default pattern
//               register width.
// Revision    : 1.0 - initial release
// ============================================================================
package seq_tx_pkg;

    // Default width of the pattern register in bits.
    localparam int c_default_width = 8;

    // Control FSM state encoding.
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        GAP   = 2'b10,
        DONE  = 2'b11
    } state_t;

endpackage : seq_tx_pkg
`default_nettype wire

// File: rtl/seq_tx_shreg.sv
`default_nettype none
// ============================================================================
// Module      : seq_tx_shreg
// Description : Pattern shift register with parallel load plus bit counter.
//               Keeps a captured copy of pattern/len so every repetition can
//               restart from the original word.
// Ports       : clk, rst_n        - clock, asynchronous active-low reset
//               load              - capture pattern/len and prime the shifter
//               reload            - restart shifting from the captured word
//               shift             - advance one bit
//               pattern, len      - parallel load data
//               data_msb          - next bit to be transmitted
//               cap_msb           - MSB of the captured word
//               last              - bit counter has reached the final bit
// Revision    : 1.0 - initial release
// ============================================================================
module seq_tx_shreg
    import seq_tx_pkg::*;
#(
    parameter int WIDTH = c_default_width,
    parameter int LEN_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             reload,
    input  logic             shift,
    input  logic [WIDTH-1:0] pattern,
    input  logic [LEN_W-1:0] len,
    output logic             data_msb,
    output logic             cap_msb,
    output logic             last
);

    logic [WIDTH-1:0] r_cap_pattern;
    logic [LEN_W-1:0] r_cap_len;
    logic [WIDTH-1:0] r_data;
    logic [LEN_W-1:0] r_cnt;

    // The MSB is presented by the control FSM on the same edge that loads the
    // shifter, so the shifter is primed with the word already shifted by one
    // and the counter holds the number of bits still to come.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cap_pattern <= '0;
            r_cap_len     <= '0;
            r_data        <= '0;
            r_cnt         <= '0;
        end else if (load) begin
            r_cap_pattern <= pattern;
            r_cap_len     <= len;
            r_data        <= {pattern[WIDTH-2:0], 1'b0};
            r_cnt         <= len;
        end else if (reload) begin
            r_data        <= {r_cap_pattern[WIDTH-2:0], 1'b0};
            r_cnt         <= r_cap_len;
        end else if (shift) begin
            r_data        <= {r_data[WIDTH-2:0], 1'b0};
            r_cnt         <= r_cnt - LEN_W'(1);
        end
    end

    assign data_msb = r_data[WIDTH-1];
    assign cap_msb  = r_cap_pattern[WIDTH-1];
    assign last     = (r_cnt == '0);

endmodule : seq_tx_shreg
`default_nettype wire

// File: rtl/seq_tx.sv
`default_nettype none
// ============================================================================
// Module      : seq_tx
// Description : Serial pattern transmitter. Sends the top len+1 bits of a
//               captured pattern MSB first, reps+1 times, with a one-cycle
//               gap between repetitions and a one-cycle done pulse at the end.
// Ports       : clk, rst_n        - clock, asynchronous active-low reset
//               load_valid/ready  - pattern load handshake
//               pattern, len, reps- transfer description, captured on load
//               abort             - synchronous cancel, highest priority
//               x_out, x_valid    - serial bit stream and its qualifier
//               busy, done        - in-progress flag, completion pulse
// Revision    : 1.0 - initial release
// ============================================================================
module seq_tx
    import seq_tx_pkg::*;
#(
    parameter int WIDTH = c_default_width
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     load_valid,
    output logic                     load_ready,
    input  logic [WIDTH-1:0]         pattern,
    input  logic [$clog2(WIDTH)-1:0] len,
    input  logic [3:0]               reps,
    input  logic                     abort,
    output logic                     x_out,
    output logic                     x_valid,
    output logic                     busy,
    output logic                     done
);

    localparam int LEN_W = $clog2(WIDTH);

    state_t     r_state;
    logic [3:0] r_reps;

    logic w_load;
    logic w_reload;
    logic w_shift;
    logic w_data_msb;
    logic w_cap_msb;
    logic w_last;

    assign w_load   = (r_state == IDLE) && load_ready && load_valid && !abort;
    assign w_reload = (r_state == GAP) && !abort;
    assign w_shift  = (r_state == SHIFT) && !w_last && !abort;

    seq_tx_shreg #(
        .WIDTH (WIDTH),
        .LEN_W (LEN_W)
    ) u_shreg (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (w_load),
        .reload   (w_reload),
        .shift    (w_shift),
        .pattern  (pattern),
        .len      (len),
        .data_msb (w_data_msb),
        .cap_msb  (w_cap_msb),
        .last     (w_last)
    );

    // Outputs describe the state being entered, so every output defaults to
    // 0 and each transition raises only what the next cycle needs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_reps     <= 4'd0;
            load_ready <= 1'b0;
            x_out      <= 1'b0;
            x_valid    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            load_ready <= 1'b0;
            x_out      <= 1'b0;
            x_valid    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            if (abort) begin
                // load_ready stays low for the cycle after an abort.
                r_state <= IDLE;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (load_ready && load_valid) begin
                            r_state <= SHIFT;
                            r_reps  <= reps;
                            x_out   <= pattern[WIDTH-1];
                            x_valid <= 1'b1;
                            busy    <= 1'b1;
                        end else begin
                            load_ready <= 1'b1;
                        end
                    end
                    SHIFT: begin
                        if (!w_last) begin
                            x_out   <= w_data_msb;
                            x_valid <= 1'b1;
                            busy    <= 1'b1;
                        end else if (r_reps != 4'd0) begin
                            r_state <= GAP;
                            r_reps  <= r_reps - 4'd1;
                            busy    <= 1'b1;
                        end else begin
                            r_state <= DONE;
                            done    <= 1'b1;
                        end
                    end
                    GAP: begin
                        r_state <= SHIFT;
                        x_out   <= w_cap_msb;
                        x_valid <= 1'b1;
                        busy    <= 1'b1;
                    end
                    DONE: begin
                        r_state    <= IDLE;
                        load_ready <= 1'b1;
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

endmodule : seq_tx
`default_nettype wire

// File: tb/tb_seq_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_tx
// Description : Self-checking bench for seq_tx. Expected per-cycle output
//               streams are built from the transfer description (bits, gaps,
//               done) and compared against the DUT one cycle at a time.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_tx;

    localparam int W = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       load_valid = 1'b0;
    logic       load_ready;
    logic [7:0] pattern = 8'h00;
    logic [2:0] len = 3'd0;
    logic [3:0] reps = 4'd0;
    logic       abort = 1'b0;
    logic       x_out;
    logic       x_valid;
    logic       busy;
    logic       done;

    int checks = 0;
    int errors = 0;

    // Observation vector: {load_ready, x_valid, x_out, busy, done}
    logic [4:0] exp_q[$];
    logic [3:0] hist_dut;
    logic [3:0] hist_ref;
    int         y_count;

    typedef struct {
        logic [7:0] pattern;
        int         len;
        int         reps;
        int         exp_valid;
        int         exp_ones;
        int         exp_busy;
    } vec_t;

    vec_t tbl[6];

    seq_tx #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .pattern    (pattern),
        .len        (len),
        .reps       (reps),
        .abort      (abort),
        .x_out      (x_out),
        .x_valid    (x_valid),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    function automatic logic [4:0] obs();
        return {load_ready, x_valid, x_out, busy, done};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected stream after acceptance: len+1 bits per repetition, one gap
    // cycle between repetitions, then a single done cycle.
    task automatic build_exp(input logic [7:0] p, input int l, input int r);
        exp_q.delete();
        for (int k = 0; k <= r; k++) begin
            for (int i = 0; i <= l; i++)
                exp_q.push_back({1'b0, 1'b1, p[7-i], 1'b1, 1'b0});
            if (k < r)
                exp_q.push_back(5'b00010);
        end
        exp_q.push_back(5'b00001);
    endtask

    // Called with the DUT idle and ready; returns one cycle after done with
    // the DUT ready again. Inputs are scrambled after capture.
    task automatic run_transfer(input logic [7:0] p, input int l, input int r, input bit det,
                                output int nvalid, output int nones, output int nbusy,
                                output int ndone);
        nvalid = 0; nones = 0; nbusy = 0; ndone = 0;
        hist_dut = 4'd0; hist_ref = 4'd0; y_count = 0;
        check("ready_before_load", {31'd0, load_ready}, 32'd1);
        build_exp(p, l, r);
        load_valid = 1'b1;
        pattern    = p;
        len        = l[2:0];
        reps       = r[3:0];
        tick();
        load_valid = 1'b0;
        pattern    = 8'($urandom);
        len        = 3'($urandom_range(0, 7));
        reps       = 4'($urandom_range(0, 15));
        for (int c = 0; c < exp_q.size(); c++) begin
            check("stream", {27'd0, obs()}, {27'd0, exp_q[c]});
            nvalid += int'(x_valid);
            nones  += int'(x_valid & x_out);
            nbusy  += int'(busy);
            ndone  += int'(done);
            if (det) begin
                hist_dut = {hist_dut[2:0], x_out};
                hist_ref = {hist_ref[2:0], exp_q[c][2]};
                check("detector_y", {31'd0, hist_dut == 4'b0110}, {31'd0, hist_ref == 4'b0110});
                y_count += int'(hist_dut == 4'b0110);
            end
            tick();
        end
        check("ready_after_done", {27'd0, obs()}, 32'b10000);
    endtask

    initial begin
        int nv, no, nb, nd;

        tbl[0] = '{8'b1011_0000, 3, 0, 4, 3, 4};
        tbl[1] = '{8'hA5, 7, 2, 24, 12, 26};
        tbl[2] = '{8'h80, 0, 0, 1, 1, 1};
        tbl[3] = '{8'hFF, 7, 15, 128, 128, 143};
        tbl[4] = '{8'h0F, 0, 3, 4, 0, 7};
        tbl[5] = '{8'h6C, 5, 1, 12, 8, 13};

        // Reset held across edges: everything low.
        tick();
        tick();
        check("reset_outputs", {27'd0, obs()}, 32'd0);
        #2 rst_n = 1'b1;
        tick();
        check("ready_after_reset", {27'd0, obs()}, 32'b10000);

        // Table-driven transfers.
        for (int t = 0; t < 6; t++) begin
            run_transfer(tbl[t].pattern, tbl[t].len, tbl[t].reps, 1'b0, nv, no, nb, nd);
            check("valid_count", nv, tbl[t].exp_valid);
            check("ones_count", no, tbl[t].exp_ones);
            check("busy_count", nb, tbl[t].exp_busy);
            check("done_count", nd, 1);
        end

        // Randomized transfers against the stream model.
        for (int t = 0; t < 12; t++) begin
            logic [7:0] rp;
            int rl, rr;
            rp = 8'($urandom);
            rl = $urandom_range(0, 7);
            rr = $urandom_range(0, 4);
            run_transfer(rp, rl, rr, 1'b0, nv, no, nb, nd);
            check("rand_done_count", nd, 1);
        end

        // Abort on the third bit.
        load_valid = 1'b1; pattern = 8'hFF; len = 3'd7; reps = 4'd0;
        tick();
        load_valid = 1'b0;
        check("abort_bit1", {27'd0, obs()}, 32'b01110);
        tick();
        tick();
        check("abort_bit3", {27'd0, obs()}, 32'b01110);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_next", {27'd0, obs()}, 32'd0);
        tick();
        check("abort_ready", {27'd0, obs()}, 32'b10000);
        tick();
        check("abort_no_done", {27'd0, obs()}, 32'b10000);

        // Load with abort in IDLE is refused.
        abort = 1'b1; load_valid = 1'b1; pattern = 8'hFF;
        tick();
        abort = 1'b0; load_valid = 1'b0;
        check("abort_load_refused", {27'd0, obs()}, 32'd0);
        tick();
        check("abort_load_ready", {27'd0, obs()}, 32'b10000);
        tick();
        check("abort_load_idle", {27'd0, obs()}, 32'b10000);

        // Asynchronous reset pulse mid-SHIFT.
        load_valid = 1'b1; pattern = 8'hFF; len = 3'd7; reps = 4'd3;
        tick();
        load_valid = 1'b0;
        tick();
        check("pre_reset_shift", {27'd0, obs()}, 32'b01110);
        #2 rst_n = 1'b0;
        #1 check("async_reset", {27'd0, obs()}, 32'd0);
        #1 rst_n = 1'b1;
        tick();
        check("post_reset_ready", {27'd0, obs()}, 32'b10000);
        run_transfer(8'b1011_0000, 3, 0, 1'b0, nv, no, nb, nd);
        check("post_reset_done", nd, 1);

        // Stream into the 0110 sequence detector.
        run_transfer(8'b0110_0000, 3, 1, 1'b1, nv, no, nb, nd);
        check("detector_hits", y_count, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_seq_tx
`default_nettype wire
